fifo_cr: RTL and testbench
==========================

// Module: fifo_cr
// PURPOSE
//   Parametrised single-clock show-ahead FIFO with credit return. Width and
//   power-of-two depth are configurable. Provides fill level, almost-full and
//   almost-empty flags, sticky overflow/underflow error flags, and a one-cycle
//   credit pulse per freed slot. Sits at the receive side of credit-based links.
// PARAMETERS
//   WIDTH       8   data word width, bits (>=1)
//   DEPTH_LOG2  3   log2 of entry count; DEPTH = 2**DEPTH_LOG2 (1..12)
//   AFULL_LVL   6   afull asserted when level >= AFULL_LVL (1..DEPTH)
//   AEMPTY_LVL  1   aempty asserted when level <= AEMPTY_LVL (0..DEPTH-1)
// PORTS
//   clk       in   1               clock, rising edge
//   reset_p   in   1               asynchronous reset, active high
//   data_i    in   WIDTH           write data
//   data_we   in   1               write request
//   data_o    out  WIDTH           head-of-queue data (show-ahead), valid when !empty
//   data_rd   in   1               read request, pops head
//   full      out  1               level == DEPTH
//   empty     out  1               level == 0
//   afull     out  1               level >= AFULL_LVL
//   aempty    out  1               level <= AEMPTY_LVL
//   level     out  DEPTH_LOG2+1    current entry count, 0..DEPTH
//   credit_o  out  1               one-cycle pulse per accepted read
//   ovf       out  1               sticky: write attempted while full
//   udf       out  1               sticky: read attempted while empty
//   err_clr   in   1               clears ovf and udf
// BEHAVIOUR
//   - Reset (async assert, clocked release): wr_ptr=rd_ptr=0, level=0, empty=1,
//     full=0, afull=0, aempty=1, credit_o=0, ovf=0, udf=0. Memory not reset;
//     data_o is don't-care while empty.
//   - Pointers are DEPTH_LOG2+1 bits; low bits index memory, MSB is the wrap
//     bit. empty: pointers equal. full: low bits equal, MSB differs.
//   - Write accepted iff data_we & !full (flags as before the edge): mem[wr_ptr]
//     <= data_i, wr_ptr+1 (mod 2**(DEPTH_LOG2+1)).
//   - Read accepted iff data_rd & !empty: rd_ptr+1. data_o = mem[rd_ptr]
//     combinationally; the first written word appears on data_o the cycle
//     after its write edge (write-to-read latency 1 clock).
//   - Simultaneous accepted write+read: both happen, level unchanged. When
//     full, a same-cycle write is rejected even if a read is accepted (sets
//     ovf). When empty, a same-cycle read is rejected (sets udf); write proceeds.
//   - level is a register updated on the same edge as pointers:
//     +1 write only, -1 read only, unchanged both/neither. Always equals
//     wr_ptr - rd_ptr. full/empty/afull/aempty decoded from level/pointers
//     registers only (no input-to-flag combinational paths).
//   - credit_o: registered, high for the cycle after each accepted read;
//     back-to-back reads give continuous high. Sender starts with DEPTH credits
//     after reset; no credit pulses are issued on reset release.
//   - ovf/udf: set on rejected write/read, hold until err_clr. Set wins over
//     err_clr in the same cycle. Rejected accesses never move pointers/level.
//   - Reset mid-operation: all contents discarded, state as above regardless
//     of in-flight requests; pending credit pulse is dropped.
//   - Parameter sanity (AFULL_LVL<=DEPTH, AEMPTY_LVL<DEPTH) checked by an
//     elaboration-time assertion.
// TESTING (WIDTH=8, DEPTH_LOG2=3, AFULL_LVL=6, AEMPTY_LVL=1)
//   1 Reset then 8 writes 0x10..0x17 -> level 1..8, afull at level 6, full at 8;
//     data_o=0x10 one cycle after first write; ovf stays 0.
//   2 9th write while full -> rejected, level stays 8, ovf=1; err_clr -> ovf=0.
//   3 Drain 8 reads -> data_o 0x10..0x17 in order, credit_o 8 pulses each one
//     cycle after read edge, empty=1, aempty at level<=1; 9th read -> udf=1.
//   4 Run 20 entries through with level held at 3 via simultaneous we+rd ->
//     pointer wrap, order preserved, level constant 3, credit_o high each cycle.
//   5 Full + simultaneous we+rd -> read accepted, write rejected, level 7,
//     ovf=1; empty + we+rd -> write accepted, udf=1, level 1.
//   6 Assert reset_p mid-burst between clock edges -> outputs reach reset values
//     immediately (async), credit_o=0, subsequent write starts at index 0.

Source files
------------

// File: rtl/fifo_cr.sv
// ============================================================================
// fifo_cr : single-clock show-ahead FIFO with credit return, fill-level flags
//           and sticky overflow/underflow error flags.
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_cr #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 3,
   parameter int AFULL_LVL  = 6,
   parameter int AEMPTY_LVL = 1
) (
   input  logic                  clk,
   input  logic                  reset_p,
   input  logic [WIDTH-1:0]      data_i,
   input  logic                  data_we,
   output logic [WIDTH-1:0]      data_o,
   input  logic                  data_rd,
   output logic                  full,
   output logic                  empty,
   output logic                  afull,
   output logic                  aempty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  credit_o,
   output logic                  ovf,
   output logic                  udf,
   input  logic                  err_clr
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int AW    = DEPTH_LOG2 + 1;

   localparam logic [AW-1:0] AFULL_C  = AW'(AFULL_LVL);
   localparam logic [AW-1:0] AEMPTY_C = AW'(AEMPTY_LVL);
   localparam logic [AW-1:0] ONE_C    = AW'(1);

   generate
      if ((AFULL_LVL < 1) || (AFULL_LVL > DEPTH) ||
          (AEMPTY_LVL < 0) || (AEMPTY_LVL >= DEPTH)) begin : g_bad_params
         $error("fifo_cr: AFULL_LVL must be 1..DEPTH and AEMPTY_LVL 0..DEPTH-1");
      end
   endgenerate

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] level_q,  level_d;
   logic          credit_q, credit_d;
   logic          ovf_q,    ovf_d;
   logic          udf_q,    udf_d;

   logic          full_w;
   logic          empty_w;
   logic          wr_acc_w;
   logic          rd_acc_w;

   // Flags depend only on registered state, never on the request inputs.
   assign empty_w  = (wr_ptr_q == rd_ptr_q);
   assign full_w   = (wr_ptr_q[AW-1] != rd_ptr_q[AW-1]) &&
                     (wr_ptr_q[AW-2:0] == rd_ptr_q[AW-2:0]);

   assign wr_acc_w = data_we & ~full_w;
   assign rd_acc_w = data_rd & ~empty_w;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_acc_w) begin
         wr_ptr_d = wr_ptr_q + ONE_C;
      end
      if (rd_acc_w) begin
         rd_ptr_d = rd_ptr_q + ONE_C;
      end
      case ({wr_acc_w, rd_acc_w})
         2'b10:   level_d = level_q + ONE_C;
         2'b01:   level_d = level_q - ONE_C;
         default: level_d = level_q;
      endcase
      credit_d = rd_acc_w;
      // A new error event wins over a simultaneous clear.
      ovf_d    = (ovf_q & ~err_clr) | (data_we & full_w);
      udf_d    = (udf_q & ~err_clr) | (data_rd & empty_w);
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         credit_q <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         credit_q <= credit_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc_w) begin
         mem_q[wr_ptr_q[AW-2:0]] <= data_i;
      end
   end

   assign data_o   = mem_q[rd_ptr_q[AW-2:0]];
   assign full     = full_w;
   assign empty    = empty_w;
   assign afull    = (level_q >= AFULL_C);
   assign aempty   = (level_q <= AEMPTY_C);
   assign level    = level_q;
   assign credit_o = credit_q;
   assign ovf      = ovf_q;
   assign udf      = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_cr.sv
// ============================================================================
// tb_fifo_cr : directed self-checking bench for fifo_cr (8-deep, 8-bit).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fifo_cr;

   logic       clk;
   logic       reset_p;
   logic [7:0] data_i;
   logic       data_we;
   logic [7:0] data_o;
   logic       data_rd;
   logic       full;
   logic       empty;
   logic       afull;
   logic       aempty;
   logic [3:0] level;
   logic       credit_o;
   logic       ovf;
   logic       udf;
   logic       err_clr;

   int errors = 0;
   int checks = 0;

   fifo_cr #(
      .WIDTH      (8),
      .DEPTH_LOG2 (3),
      .AFULL_LVL  (6),
      .AEMPTY_LVL (1)
   ) dut (
      .clk      (clk),
      .reset_p  (reset_p),
      .data_i   (data_i),
      .data_we  (data_we),
      .data_o   (data_o),
      .data_rd  (data_rd),
      .full     (full),
      .empty    (empty),
      .afull    (afull),
      .aempty   (aempty),
      .level    (level),
      .credit_o (credit_o),
      .ovf      (ovf),
      .udf      (udf),
      .err_clr  (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and land 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_p = 1'b1;
      data_i  = '0;
      data_we = 1'b0;
      data_rd = 1'b0;
      err_clr = 1'b0;
      tick();
      tick();
      reset_p = 1'b0;
      tick();

      check("rst_level",  level,    0);
      check("rst_empty",  empty,    1);
      check("rst_full",   full,     0);
      check("rst_afull",  afull,    0);
      check("rst_aempty", aempty,   1);
      check("rst_credit", credit_o, 0);
      check("rst_ovf",    ovf,      0);
      check("rst_udf",    udf,      0);

      // Fill with 0x10..0x17
      for (int i = 0; i < 8; i++) begin
         data_i  = 8'h10 + 8'(i);
         data_we = 1'b1;
         tick();
         check("fill_level",  level,  i + 1);
         check("fill_head",   data_o, 8'h10);
         check("fill_afull",  afull,  (i + 1) >= 6);
         check("fill_full",   full,   (i + 1) == 8);
         check("fill_aempty", aempty, (i + 1) <= 1);
         check("fill_ovf",    ovf,    0);
      end
      data_we = 1'b0;

      // Write while full: rejected, ovf sticky, set beats clear
      data_i  = 8'hAA;
      data_we = 1'b1;
      tick();
      data_we = 1'b0;
      check("ovf_level", level, 8);
      check("ovf_set",   ovf,   1);
      check("ovf_full",  full,  1);
      check("ovf_head",  data_o, 8'h10);
      data_we = 1'b1;
      err_clr = 1'b1;
      tick();
      check("ovf_setwins", ovf, 1);
      data_we = 1'b0;
      tick();
      check("ovf_clr", ovf, 0);
      err_clr = 1'b0;
      tick();
      check("ovf_held_clr", ovf, 0);

      // Drain in order with one credit per read
      for (int i = 0; i < 8; i++) begin
         check("drain_data", data_o, 8'h10 + 8'(i));
         data_rd = 1'b1;
         tick();
         check("drain_credit", credit_o, 1);
         check("drain_level",  level,    7 - i);
         check("drain_aempty", aempty,   (7 - i) <= 1);
         check("drain_empty",  empty,    i == 7);
      end
      data_rd = 1'b0;
      tick();
      check("drain_credit_end", credit_o, 0);
      data_rd = 1'b1;
      tick();
      data_rd = 1'b0;
      check("udf_set",    udf,      1);
      check("udf_level",  level,    0);
      check("udf_credit", credit_o, 0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("udf_clr", udf, 0);

      // Steady state at level 3 with pointer wrap
      for (int i = 0; i < 3; i++) begin
         data_i  = 8'h20 + 8'(i);
         data_we = 1'b1;
         tick();
      end
      check("steady_pre_level", level, 3);
      for (int k = 0; k < 20; k++) begin
         check("steady_data", data_o, 8'h20 + 8'(k));
         data_i  = 8'h23 + 8'(k);
         data_we = 1'b1;
         data_rd = 1'b1;
         tick();
         check("steady_level",  level,    3);
         check("steady_credit", credit_o, 1);
      end
      data_we = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("steady_tail", data_o, 8'h34 + 8'(i));
         tick();
      end
      data_rd = 1'b0;
      check("steady_empty", empty, 1);
      check("steady_udf",   udf,   0);

      // Full with simultaneous write+read
      for (int i = 0; i < 8; i++) begin
         data_i  = 8'h40 + 8'(i);
         data_we = 1'b1;
         tick();
      end
      check("fr_full", full, 1);
      data_i  = 8'h99;
      data_we = 1'b1;
      data_rd = 1'b1;
      tick();
      data_we = 1'b0;
      data_rd = 1'b0;
      check("fr_level",  level,    7);
      check("fr_ovf",    ovf,      1);
      check("fr_credit", credit_o, 1);
      check("fr_head",   data_o,   8'h41);
      data_rd = 1'b1;
      for (int i = 0; i < 7; i++) begin
         check("fr_drain", data_o, 8'h41 + 8'(i));
         tick();
      end
      data_rd = 1'b0;
      check("fr_empty", empty, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("fr_ovf_clr", ovf, 0);

      // Empty with simultaneous write+read
      data_i  = 8'h55;
      data_we = 1'b1;
      data_rd = 1'b1;
      tick();
      data_we = 1'b0;
      data_rd = 1'b0;
      check("er_level",  level,    1);
      check("er_udf",    udf,      1);
      check("er_head",   data_o,   8'h55);
      check("er_credit", credit_o, 0);
      check("er_empty",  empty,    0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("er_udf_clr", udf, 0);

      // Asynchronous reset mid-burst
      data_i  = 8'h60;
      data_we = 1'b1;
      tick();
      data_i  = 8'h61;
      data_rd = 1'b1;
      tick();
      check("ar_pre_level",  level,    2);
      check("ar_pre_credit", credit_o, 1);
      data_i = 8'h62;
      #3;
      reset_p = 1'b1;
      #1;
      check("ar_level",  level,    0);
      check("ar_empty",  empty,    1);
      check("ar_full",   full,     0);
      check("ar_aempty", aempty,   1);
      check("ar_afull",  afull,    0);
      check("ar_credit", credit_o, 0);
      check("ar_ovf",    ovf,      0);
      check("ar_udf",    udf,      0);
      data_we = 1'b0;
      data_rd = 1'b0;
      tick();
      reset_p = 1'b0;
      tick();
      check("ar_rel_credit", credit_o, 0);
      check("ar_rel_level",  level,    0);
      data_i  = 8'h77;
      data_we = 1'b1;
      tick();
      data_we = 1'b0;
      check("ar_post_level", level,  1);
      check("ar_post_head",  data_o, 8'h77);
      data_rd = 1'b1;
      tick();
      data_rd = 1'b0;
      check("ar_post_credit", credit_o, 1);
      check("ar_post_empty",  empty,    1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
